alu_ctrl: RTL and testbench

- Sequencer on the instruction side of the 8-bit ALU.
- Fetches 8-bit instructions from instruction memory over a req/ack handshake.
- Decodes each instruction into the one-hot ALU enable vector and drives the ALU operands: accumulator on `a`, bus on `b`.
- Writes the ALU result back to the accumulator, latches branch flags, and steers the PC.
- Owns the accumulator and a 4-entry register file; sits between imem and the ALU.

---
 rtl/alu_ctrl_pkg.sv | 58 +++++
 rtl/alu_ctrl_insn_decode.sv | 45 ++++
 rtl/alu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared widths, opcode map, ALU enable/flag bit indices,
// FSM state encodings and the decoded-control payload for alu_ctrl.
package alu_ctrl_pkg;

    localparam int unsigned BIT_W          = 8;
    localparam int unsigned REG_N          = 4;
    localparam int unsigned OP_W           = 4;
    localparam int unsigned IMM_W          = 4;
    localparam int unsigned ISA_INSN_COUNT = 8;
    localparam int unsigned ALU_FLAG_COUNT = 2;

    // ALU flag bits as delivered by the comparator: {GT, EQ}
    localparam int unsigned ALU_FLAG_EQ = 0;
    localparam int unsigned ALU_FLAG_GT = 1;

    // One-hot ALU enable bit positions (opcode - 1)
    localparam int unsigned ISA_ADD  = 0;
    localparam int unsigned ISA_ADDI = 1;
    localparam int unsigned ISA_SH   = 2;
    localparam int unsigned ISA_SHI  = 3;
    localparam int unsigned ISA_NOT  = 4;
    localparam int unsigned ISA_AND  = 5;
    localparam int unsigned ISA_OR   = 6;
    localparam int unsigned ISA_XOR  = 7;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
    localparam logic [OP_W-1:0] OP_SH   = 4'h3;
    localparam logic [OP_W-1:0] OP_SHI  = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h5;
    localparam logic [OP_W-1:0] OP_AND  = 4'h6;
    localparam logic [OP_W-1:0] OP_OR   = 4'h7;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
    localparam logic [OP_W-1:0] OP_LD   = 4'h9;
    localparam logic [OP_W-1:0] OP_ST   = 4'hA;
    localparam logic [OP_W-1:0] OP_CMP  = 4'hB;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'hC;
    localparam logic [OP_W-1:0] OP_BGT  = 4'hD;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    // Non-ALU control decoded in DECODE and consumed in EXEC
    typedef struct packed {
        logic is_branch;
        logic is_ld;
        logic is_st;
        logic is_cmp;
        logic is_jmp;
        logic is_halt;
    } ctl_t;

endpackage

// File: rtl/alu_ctrl_insn_decode.sv
// alu_ctrl_insn_decode: combinational opcode decoder.
//   i_opcode    - instruction bits [7:4]
//   o_insn_en   - one-hot ALU enable (opcodes 1-8), else zero
//   o_b_sel_imm - bus takes the zero-extended immediate (ADDI/SHI)
//   o_ctl       - branch/load/store/compare/jump/halt controls
module alu_ctrl_insn_decode
    import alu_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]           i_opcode,
    output logic [ISA_INSN_COUNT-1:0] o_insn_en,
    output logic                      o_b_sel_imm,
    output ctl_t                      o_ctl
);

    always_comb begin
        o_insn_en   = '0;
        o_b_sel_imm = 1'b0;
        o_ctl       = '0;
        case (i_opcode)
            OP_ADD:  o_insn_en[ISA_ADD] = 1'b1;
            OP_ADDI: begin
                o_insn_en[ISA_ADDI] = 1'b1;
                o_b_sel_imm         = 1'b1;
            end
            OP_SH:   o_insn_en[ISA_SH] = 1'b1;
            OP_SHI:  begin
                o_insn_en[ISA_SHI] = 1'b1;
                o_b_sel_imm        = 1'b1;
            end
            OP_NOT:  o_insn_en[ISA_NOT] = 1'b1;
            OP_AND:  o_insn_en[ISA_AND] = 1'b1;
            OP_OR:   o_insn_en[ISA_OR]  = 1'b1;
            OP_XOR:  o_insn_en[ISA_XOR] = 1'b1;
            OP_LD:   o_ctl.is_ld     = 1'b1;
            OP_ST:   o_ctl.is_st     = 1'b1;
            OP_CMP:  o_ctl.is_cmp    = 1'b1;
            OP_BEQ,
            OP_BGT:  o_ctl.is_branch = 1'b1;
            OP_JMP:  o_ctl.is_jmp    = 1'b1;
            OP_HALT: o_ctl.is_halt   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: instruction sequencer in front of the 8-bit ALU.
//   clk, rst               - clock, synchronous active-high reset
//   imem_req/addr/ack/data - instruction fetch handshake (addr = pc)
//   insn_en, alu_a, alu_b  - registered ALU controls/operands (a = acc)
//   alu_c, alu_flags       - ALU result and {GT, EQ} comparator flags
//   acc, pc, halted        - architectural state visibility
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned BIT_COUNT = BIT_W,
    parameter int unsigned REG_COUNT = REG_N
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [BIT_COUNT-1:0]      imem_addr,
    input  logic                      imem_ack,
    input  logic [7:0]                imem_data,
    output logic [ISA_INSN_COUNT-1:0] insn_en,
    output logic [BIT_COUNT-1:0]      alu_a,
    output logic [BIT_COUNT-1:0]      alu_b,
    input  logic [BIT_COUNT-1:0]      alu_c,
    input  logic [ALU_FLAG_COUNT-1:0] alu_flags,
    output logic [BIT_COUNT-1:0]      acc,
    output logic [BIT_COUNT-1:0]      pc,
    output logic                      halted
);

    localparam int unsigned RS_W = $clog2(REG_COUNT);

    logic [1:0]                r_state;
    logic                      r_req;
    logic [BIT_COUNT-1:0]      r_pc;
    logic [BIT_COUNT-1:0]      r_acc;
    logic [BIT_COUNT-1:0]      r_regs [REG_COUNT];
    logic [ALU_FLAG_COUNT-1:0] r_flags;
    logic [7:0]                r_ir;
    logic [ISA_INSN_COUNT-1:0] r_insn_en;
    logic [BIT_COUNT-1:0]      r_alu_b;
    ctl_t                      r_ctl;
    logic                      r_halted;

    logic [1:0]                w_state_nxt;
    logic                      w_req_nxt;
    logic [BIT_COUNT-1:0]      w_pc_nxt;
    logic [BIT_COUNT-1:0]      w_acc_nxt;
    logic [ALU_FLAG_COUNT-1:0] w_flags_nxt;
    logic [7:0]                w_ir_nxt;
    logic [ISA_INSN_COUNT-1:0] w_insn_en_nxt;
    logic [BIT_COUNT-1:0]      w_alu_b_nxt;
    ctl_t                      w_ctl_nxt;
    logic                      w_halted_nxt;
    logic                      w_reg_we;

    logic [ISA_INSN_COUNT-1:0] w_dec_en;
    logic                      w_dec_b_sel_imm;
    ctl_t                      w_dec_ctl;
    logic [RS_W-1:0]           w_rs;
    logic [IMM_W-1:0]          w_imm;
    logic [BIT_COUNT-1:0]      w_imm_zx;
    logic [BIT_COUNT-1:0]      w_imm_sx;
    logic                      w_br_flag;

    alu_ctrl_insn_decode u_decode (
        .i_opcode    (r_ir[7:4]),
        .o_insn_en   (w_dec_en),
        .o_b_sel_imm (w_dec_b_sel_imm),
        .o_ctl       (w_dec_ctl)
    );

    assign w_rs     = r_ir[RS_W-1:0];
    assign w_imm    = r_ir[IMM_W-1:0];
    assign w_imm_zx = BIT_COUNT'(w_imm);
    assign w_imm_sx = {{(BIT_COUNT-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    // BEQ (0xC) and BGT (0xD) differ only in opcode bit 0 (ir[4])
    assign w_br_flag = r_ir[4] ? r_flags[ALU_FLAG_GT] : r_flags[ALU_FLAG_EQ];

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_req_nxt     = r_req;
        w_pc_nxt      = r_pc;
        w_acc_nxt     = r_acc;
        w_flags_nxt   = r_flags;
        w_ir_nxt      = r_ir;
        w_insn_en_nxt = r_insn_en;
        w_alu_b_nxt   = r_alu_b;
        w_ctl_nxt     = r_ctl;
        w_halted_nxt  = r_halted;
        w_reg_we      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // ack only counts while our request is visible
                if (r_req && imem_ack) begin
                    w_ir_nxt    = imem_data;
                    w_pc_nxt    = r_pc + BIT_COUNT'(1);
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_DECODE;
                end else begin
                    w_req_nxt = 1'b1;
                end
            end
            ST_DECODE: begin
                w_insn_en_nxt = w_dec_en;
                w_ctl_nxt     = w_dec_ctl;
                w_alu_b_nxt   = w_dec_b_sel_imm ? w_imm_zx : r_regs[w_rs];
                w_state_nxt   = ST_EXEC;
            end
            ST_EXEC: begin
                w_insn_en_nxt = '0;
                w_state_nxt   = ST_FETCH;
                // raise req now so the next fetch can complete in one cycle
                w_req_nxt     = 1'b1;
                if (|r_insn_en) begin
                    w_acc_nxt   = alu_c;
                    w_flags_nxt = alu_flags;
                end
                if (r_ctl.is_cmp) begin
                    w_flags_nxt = alu_flags;
                end
                if (r_ctl.is_ld) begin
                    w_acc_nxt = r_regs[w_rs];
                end
                if (r_ctl.is_st) begin
                    w_reg_we = 1'b1;
                end
                if (r_ctl.is_branch && w_br_flag) begin
                    w_pc_nxt = r_pc + w_imm_sx;
                end
                if (r_ctl.is_jmp) begin
                    w_pc_nxt = r_acc;
                end
                if (r_ctl.is_halt) begin
                    w_state_nxt  = ST_HALT;
                    w_req_nxt    = 1'b0;
                    w_halted_nxt = 1'b1;
                end
            end
            ST_HALT: begin
                w_req_nxt     = 1'b0;
                w_insn_en_nxt = '0;
                w_halted_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_req     <= 1'b0;
            r_pc      <= '0;
            r_acc     <= '0;
            r_regs    <= '{default: '0};
            r_flags   <= '0;
            r_ir      <= '0;
            r_insn_en <= '0;
            r_alu_b   <= '0;
            r_ctl     <= '0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req     <= w_req_nxt;
            r_pc      <= w_pc_nxt;
            r_acc     <= w_acc_nxt;
            r_flags   <= w_flags_nxt;
            r_ir      <= w_ir_nxt;
            r_insn_en <= w_insn_en_nxt;
            r_alu_b   <= w_alu_b_nxt;
            r_ctl     <= w_ctl_nxt;
            r_halted  <= w_halted_nxt;
            if (w_reg_we) begin
                r_regs[w_rs] <= r_acc;
            end
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign insn_en   = r_insn_en;
    assign alu_a     = r_acc;
    assign alu_b     = r_alu_b;
    assign acc       = r_acc;
    assign pc        = r_pc;
    assign halted    = r_halted;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: self-checking bench for alu_ctrl. Provides an instruction
// memory responder and a behavioural ALU, and compares the DUT against an
// instruction-level reference model of the architectural state.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] insn_en;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_c;
    logic [1:0] alu_flags;
    logic [7:0] acc;
    logic [7:0] pc;
    logic       halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    // instruction-level reference state
    logic [7:0] m_pc, m_acc;
    logic [7:0] m_r [4];
    logic [1:0] m_flags;
    logic       m_halted;

    // per-instruction observations and expectations
    logic [7:0] t_insn, t_addr, t_en, t_b, t_en_a;
    logic       t_held, t_req_a, t_to;
    logic [7:0] e_en, e_b, pc_before;
    logic       e_bchk;
    logic [3:0] env_op;

    alu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .insn_en   (insn_en),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_flags (alu_flags),
        .acc       (acc),
        .pc        (pc),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1, 4'd2: return a + b;
            4'd3, 4'd4: return a << b[2:0];
            4'd5:       return ~a;
            4'd6:       return a & b;
            4'd7:       return a | b;
            4'd8:       return a ^ b;
            default:    return 8'h00;
        endcase
    endfunction

    // behavioural ALU in the environment
    always_comb begin
        env_op = 4'd0;
        for (int i = 0; i < 8; i++) if (insn_en[i]) env_op = 4'(i + 1);
        alu_c = alu_ref(env_op, alu_a, alu_b);
    end
    assign alu_flags = {alu_a > alu_b, alu_a == alu_b};

    task automatic model_reset();
        m_pc = 8'h00; m_acc = 8'h00; m_flags = 2'b00; m_halted = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] insn, output logic [7:0] x_en,
                              output logic [7:0] x_b, output logic x_bchk);
        logic [3:0] op, imm;
        logic [1:0] rs;
        logic [7:0] b;
        op = insn[7:4]; imm = insn[3:0]; rs = insn[1:0];
        x_en   = (op >= 4'd1 && op <= 4'd8) ? (8'h01 << (op - 4'd1)) : 8'h00;
        b      = (op == 4'd2 || op == 4'd4) ? {4'h0, imm} : m_r[rs];
        x_b    = b;
        x_bchk = (op >= 4'd1 && op <= 4'd8) || op == 4'hB;
        m_pc   = m_pc + 8'd1;
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                m_flags = {m_acc > b, m_acc == b};
                m_acc   = alu_ref(op, m_acc, b);
            end
            4'h9: m_acc = m_r[rs];
            4'hA: m_r[rs] = m_acc;
            4'hB: m_flags = {m_acc > b, m_acc == b};
            4'hC: if (m_flags[0]) m_pc = m_pc + {{4{imm[3]}}, imm};
            4'hD: if (m_flags[1]) m_pc = m_pc + {{4{imm[3]}}, imm};
            4'hE: m_pc = m_acc;
            4'hF: m_halted = 1'b1;
            default: ;
        endcase
    endtask

    // Called and returns at a negedge. Serves one fetch after waitc stall
    // cycles, then samples EXEC and the cycle after EXEC.
    task automatic exec_insn(input int waitc);
        int n;
        n = 0; t_to = 1'b0; t_held = 1'b1; t_insn = 8'h00; t_addr = 8'h00;
        t_en = 8'h00; t_b = 8'h00; t_req_a = 1'b0; t_en_a = 8'h00;
        while (imem_req !== 1'b1 && n < 10) begin
            @(posedge clk); @(negedge clk); n++;
        end
        if (imem_req !== 1'b1) begin
            t_to = 1'b1;
            return;
        end
        t_addr = imem_addr;
        t_insn = mem[imem_addr];
        repeat (waitc) begin
            @(posedge clk); @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== t_addr) t_held = 1'b0;
        end
        imem_ack = 1'b1; imem_data = t_insn;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0; imem_data = 8'($urandom);
        @(posedge clk); @(negedge clk);
        t_en = insn_en; t_b = alu_b;
        @(posedge clk); @(negedge clk);
        t_req_a = imem_req; t_en_a = insn_en;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_data = 8'h00;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (pc !== 8'h00 || imem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h/%h want 00", pc, imem_addr); end
        checks++; if (acc !== 8'h00 || alu_a !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h want 00", acc); end
        checks++; if (insn_en !== 8'h00) begin errors++; $display("FAIL reset_insn_en: got %h want 00", insn_en); end
        checks++; if (alu_b !== 8'h00) begin errors++; $display("FAIL reset_alu_b: got %h want 00", alu_b); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        // ack while req is still low after reset must be ignored
        rst = 1'b0; imem_ack = 1'b1; imem_data = 8'hF0;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (pc !== 8'h00 || imem_req !== 1'b1) begin errors++; $display("FAIL reset_spurious_ack: pc=%h req=%b want pc=00 req=1", pc, imem_req); end
    endtask

    task automatic test_addi_wait();
        do_reset();
        mem[0] = 8'h25;
        exec_insn(2);
        model_step(t_insn, e_en, e_b, e_bchk);
        checks++; if (t_to || t_addr !== 8'h00 || !t_held) begin errors++; $display("FAIL addi_fetch: to=%b addr=%h held=%b want addr=00 held=1", t_to, t_addr, t_held); end
        checks++; if (t_en !== e_en) begin errors++; $display("FAIL addi_insn_en: got %h want %h", t_en, e_en); end
        checks++; if (t_b !== 8'h05) begin errors++; $display("FAIL addi_alu_b: got %h want 05", t_b); end
        checks++; if (acc !== m_acc) begin errors++; $display("FAIL addi_acc: got %h want %h", acc, m_acc); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL addi_pc: got %h want 01", pc); end
        checks++; if (t_en_a !== 8'h00 || t_req_a !== 1'b1) begin errors++; $display("FAIL addi_exit: en=%h req=%b want en=00 req=1", t_en_a, t_req_a); end
    endtask

    task automatic test_alu_seq();
        logic [7:0] want_acc [4];
        want_acc = '{8'd5, 8'd5, 8'd8, 8'd13};
        do_reset();
        mem[0] = 8'h25; mem[1] = 8'hA1; mem[2] = 8'h23; mem[3] = 8'h11;
        for (int s = 0; s < 4; s++) begin
            exec_insn($urandom_range(0, 2));
            model_step(t_insn, e_en, e_b, e_bchk);
            checks++; if (t_to || acc !== want_acc[s] || acc !== m_acc) begin errors++; $display("FAIL alu_seq_acc step %0d: got %h want %h", s, acc, want_acc[s]); end
        end
        checks++; if (t_b !== 8'h05 || t_en !== 8'h01) begin errors++; $display("FAIL alu_seq_add_bus: b=%h en=%h want b=05 en=01", t_b, t_en); end
    endtask

    task automatic test_branch();
        // EQ case: R1 = acc = 7, CMP r1 at pc 3, BEQ -2 at pc 4
        do_reset();
        mem[0] = 8'h27; mem[1] = 8'hA1; mem[2] = 8'h00; mem[3] = 8'hB1; mem[4] = 8'hCE;
        for (int s = 0; s < 5; s++) begin
            exec_insn(0);
            model_step(t_insn, e_en, e_b, e_bchk);
        end
        checks++; if (t_to || pc !== 8'h03 || pc !== m_pc) begin errors++; $display("FAIL beq_taken_pc: got %h want 03", pc); end
        checks++; if (acc !== 8'h07) begin errors++; $display("FAIL cmp_acc_kept: got %h want 07", acc); end
        // not-equal case: R1 = 6, acc = 7 -> BEQ falls through, BGT -2 taken
        do_reset();
        mem[0] = 8'h26; mem[1] = 8'hA1; mem[2] = 8'h21; mem[3] = 8'hB1; mem[4] = 8'hCE; mem[5] = 8'hDE;
        for (int s = 0; s < 5; s++) begin
            exec_insn(1);
            model_step(t_insn, e_en, e_b, e_bchk);
        end
        checks++; if (t_to || pc !== 8'h05 || pc !== m_pc) begin errors++; $display("FAIL beq_not_taken_pc: got %h want 05", pc); end
        exec_insn(0);
        model_step(t_insn, e_en, e_b, e_bchk);
        checks++; if (t_to || pc !== 8'h04 || pc !== m_pc) begin errors++; $display("FAIL bgt_taken_pc: got %h want 04", pc); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        mem[0] = 8'h50; mem[1] = 8'hE0; mem[255] = 8'h00;
        exec_insn(0); model_step(t_insn, e_en, e_b, e_bchk);
        exec_insn(0); model_step(t_insn, e_en, e_b, e_bchk);
        checks++; if (t_to || pc !== 8'hFF) begin errors++; $display("FAIL jmp_pc: got %h want ff", pc); end
        exec_insn(0); model_step(t_insn, e_en, e_b, e_bchk);
        checks++; if (t_to || t_addr !== 8'hFF || pc !== 8'h00) begin errors++; $display("FAIL pc_wrap: addr=%h pc=%h want addr=ff pc=00", t_addr, pc); end
    endtask

    task automatic test_halt();
        do_reset();
        mem[0] = 8'hF0;
        exec_insn(0);
        model_step(t_insn, e_en, e_b, e_bchk);
        checks++; if (t_to || halted !== m_halted || t_req_a !== 1'b0 || t_en_a !== 8'h00) begin errors++; $display("FAIL halt_entry: halted=%b req=%b en=%h want 1/0/00", halted, t_req_a, t_en_a); end
        for (int c = 0; c < 20; c++) begin
            imem_ack = 1'($urandom_range(0, 1)); imem_data = 8'($urandom);
            @(posedge clk); @(negedge clk);
            checks++; if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h01) begin errors++; $display("FAIL halt_hold cycle %0d: req=%b halted=%b pc=%h want 0/1/01", c, imem_req, halted, pc); end
        end
        imem_ack = 1'b0;
        mem[0] = 8'h00;
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_cleared: got %b want 0", halted); end
        exec_insn(1);
        checks++; if (t_to || t_addr !== 8'h00 || pc !== 8'h01) begin errors++; $display("FAIL halt_refetch: addr=%h pc=%h want 00/01", t_addr, pc); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        mem[0] = 8'h25;
        exec_insn(0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (imem_req !== 1'b0 || pc !== 8'h00 || acc !== 8'h00) begin errors++; $display("FAIL midfetch_reset: req=%b pc=%h acc=%h want 0/00/00", imem_req, pc, acc); end
        rst = 1'b0; imem_ack = 1'b1; imem_data = 8'h2F;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (pc !== 8'h00 || acc !== 8'h00 || imem_req !== 1'b1) begin errors++; $display("FAIL midfetch_late_ack: pc=%h acc=%h req=%b want 00/00/1", pc, acc, imem_req); end
        model_reset();
        exec_insn(0);
        model_step(t_insn, e_en, e_b, e_bchk);
        checks++; if (t_to || acc !== m_acc || pc !== m_pc) begin errors++; $display("FAIL midfetch_resume: acc=%h pc=%h want %h/%h", acc, pc, m_acc, m_pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i][7:4] == 4'hF) mem[i] = 8'h00;
        end
        do_reset();
        for (int s = 0; s < 80; s++) begin
            pc_before = m_pc;
            exec_insn($urandom_range(0, 3));
            model_step(t_insn, e_en, e_b, e_bchk);
            checks++;
            if (t_to || t_addr !== pc_before || !t_held) begin
                errors++; $display("FAIL rand_fetch step %0d: to=%b addr=%h held=%b want addr=%h", s, t_to, t_addr, t_held, pc_before);
            end
            checks++;
            if (t_en !== e_en || (e_bchk && t_b !== e_b)) begin
                errors++; $display("FAIL rand_exec step %0d insn %h: en=%h b=%h want en=%h b=%h", s, t_insn, t_en, t_b, e_en, e_b);
            end
            checks++;
            if (acc !== m_acc || pc !== m_pc || halted !== 1'b0) begin
                errors++; $display("FAIL rand_state step %0d insn %h: acc=%h pc=%h want acc=%h pc=%h", s, t_insn, acc, pc, m_acc, m_pc);
            end
            checks++;
            if (t_req_a !== 1'b1 || t_en_a !== 8'h00) begin
                errors++; $display("FAIL rand_exit step %0d: req=%b en=%h want 1/00", s, t_req_a, t_en_a);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        model_reset();
        test_reset();
        test_addi_wait();
        test_alu_seq();
        test_branch();
        test_pc_wrap();
        test_halt();
        test_reset_mid_fetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
